// File: rtl/jtpopeye_rom_pkg.sv
// rtl/jtpopeye_rom_pkg.sv - shared encodings and helpers for the Popeye ROM arbiter
package jtpopeye_rom_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    typedef enum logic {
        GR_MAIN = 1'b0,
        GR_OBJ  = 1'b1
    } grant_t;

    localparam int          TAG_W           = 13;
    localparam logic [21:0] MAIN_OFFSET_DEF = 22'h0;
    localparam logic [21:0] OBJ_OFFSET_DEF  = 22'h4000;

    // 32-bit word index to 16-bit SDRAM word address (always even), 22-bit wrap
    function automatic logic [21:0] word_addr(input logic [21:0] base, input logic [TAG_W-1:0] idx);
        return base + {8'd0, idx, 1'b0};
    endfunction

endpackage

// File: rtl/jtpopeye_rom_slot.sv
// rtl/jtpopeye_rom_slot.sv - one-word tag cache with hit compare and invalidate
module jtpopeye_rom_slot #(
    parameter int TW = 13
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inval,
    input  logic          fill,
    input  logic [TW-1:0] fill_tag,
    input  logic [31:0]   fill_data,
    input  logic [TW-1:0] lookup,
    output logic          hit,
    output logic [31:0]   word
);

    logic          valid;
    logic [TW-1:0] tag;
    logic [31:0]   data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= '0;
        end else if (inval) begin
            valid <= 1'b0;
        end else if (fill) begin
            valid <= 1'b1;
            tag   <= fill_tag;
            data  <= fill_data;
        end
    end

    assign hit  = valid && (tag == lookup);
    assign word = data;

endmodule

// File: rtl/jtpopeye_rom_arb.sv
// rtl/jtpopeye_rom_arb.sv - round-robin share of the SDRAM read port between main and object ROM
module jtpopeye_rom_arb
    import jtpopeye_rom_pkg::*;
#(
    parameter logic [21:0] MAIN_OFFSET = MAIN_OFFSET_DEF,
    parameter logic [21:0] OBJ_OFFSET  = OBJ_OFFSET_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        downloading,
    input  logic        loop_rst,
    input  logic        main_cs,
    input  logic [14:0] rom_addr,
    output logic [7:0]  rom_data,
    output logic        main_ok,
    input  logic        obj_cs,
    input  logic [12:0] obj_addr,
    output logic [31:0] objrom_data,
    output logic        obj_ok,
    output logic        sdram_req,
    output logic [21:0] sdram_addr,
    input  logic        sdram_ack,
    input  logic        sdram_rdy,
    input  logic [31:0] data_read
);

    state_t            state;
    grant_t            grant;
    grant_t            last_grant;
    grant_t            pick;
    logic [TAG_W-1:0]  req_tag;
    logic              halt;
    logic              main_hit, obj_hit;
    logic              main_pend, obj_pend;
    logic              fill_en;
    logic [31:0]       main_word;

    assign halt = downloading | loop_rst;

    // ack+rdy together in ISSUE completes the fetch without visiting WAIT
    assign fill_en = !halt && sdram_rdy &&
                     ((state == WAIT) || (state == ISSUE && sdram_ack));

    jtpopeye_rom_slot #(.TW(TAG_W)) u_main_slot (
        .clk       (clk),
        .rst       (rst),
        .inval     (halt),
        .fill      (fill_en && grant == GR_MAIN),
        .fill_tag  (req_tag),
        .fill_data (data_read),
        .lookup    (rom_addr[14:2]),
        .hit       (main_hit),
        .word      (main_word)
    );

    jtpopeye_rom_slot #(.TW(TAG_W)) u_obj_slot (
        .clk       (clk),
        .rst       (rst),
        .inval     (halt),
        .fill      (fill_en && grant == GR_OBJ),
        .fill_tag  (req_tag),
        .fill_data (data_read),
        .lookup    (obj_addr),
        .hit       (obj_hit),
        .word      (objrom_data)
    );

    assign main_ok   = main_cs && main_hit;
    assign obj_ok    = obj_cs && obj_hit;
    assign rom_data  = main_word[{rom_addr[1:0], 3'b000} +: 8];
    assign main_pend = main_cs && !main_hit;
    assign obj_pend  = obj_cs && !obj_hit;

    always_comb begin
        pick = GR_OBJ;
        if (main_pend && obj_pend)
            pick = (last_grant == GR_MAIN) ? GR_OBJ : GR_MAIN;
        else if (main_pend)
            pick = GR_MAIN;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= GR_MAIN;
            last_grant <= GR_OBJ;
            req_tag    <= '0;
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
        end else if (halt) begin
            state     <= IDLE;
            sdram_req <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (main_pend || obj_pend) begin
                        grant     <= pick;
                        sdram_req <= 1'b1;
                        state     <= ISSUE;
                        if (pick == GR_MAIN) begin
                            req_tag    <= rom_addr[14:2];
                            sdram_addr <= word_addr(MAIN_OFFSET, rom_addr[14:2]);
                        end else begin
                            req_tag    <= obj_addr;
                            sdram_addr <= word_addr(OBJ_OFFSET, obj_addr);
                        end
                    end
                end
                ISSUE: begin
                    if (sdram_ack) begin
                        sdram_req <= 1'b0;
                        if (sdram_rdy) begin
                            last_grant <= grant;
                            state      <= IDLE;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (sdram_rdy) begin
                        last_grant <= grant;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
